maxpool2x2_stream: RTL and testbench

//   Streaming 2x2 / stride-2 max-pooling stage that sits directly downstream of the conv/ReLU output stream.

---
 rtl/maxpool2x2_stream_if.sv | 27 ++
 rtl/maxpool2x2_stream.sv | 118 +++++++++++
 tb/tb_maxpool2x2_stream.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/maxpool2x2_stream_if.sv
// Pixel-stream interface for the 2x2 max-pooling stage: input pixels in, window maxima out.
// The master drives pixels; the slave (the pooling stage) returns maxima and the frame marker.
interface maxpool2x2_stream_if #(
   parameter int N = 16
);
   logic signed [N-1:0] din;
   logic                valid;
   logic signed [N-1:0] pool_out;
   logic                pool_valid;
   logic                frame_done;

   modport master (
      output din,
      output valid,
      input  pool_out,
      input  pool_valid,
      input  frame_done
   );

   modport slave (
      input  din,
      input  valid,
      output pool_out,
      output pool_valid,
      output frame_done
   );
endinterface

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 / stride-2 signed max-pool over a raster-scan single-channel feature map.
// Even rows park horizontal pair maxima in a half-width line buffer; odd rows combine and emit.
module maxpool2x2_stream #(
   parameter int N     = 16,
   parameter int IMG_W = 28,
   parameter int IMG_H = 28
) (
   input  logic              clk,
   input  logic              reset,
   maxpool2x2_stream_if.slave s
);

   localparam int HW = IMG_W / 2;
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam int LW = (HW > 1) ? $clog2(HW) : 1;
   localparam logic signed [N-1:0] MIN_NEG = {1'b1, {(N-1){1'b0}}};

   typedef enum logic {
      ROW_EVEN = 1'b0,
      ROW_ODD  = 1'b1
   } rowState_t;

   rowState_t           state_q, state_d;
   logic [CW-1:0]       col_q, col_d;
   logic [RW-1:0]       row_q, row_d;
   logic signed [N-1:0] pair_q, pair_d;
   logic signed [N-1:0] pool_out_q, pool_out_d;
   logic                pool_valid_q, pool_valid_d;
   logic                frame_done_q, frame_done_d;
   logic signed [N-1:0] lbuf_q [HW];

   logic [LW-1:0]       lbufIdx;
   logic signed [N-1:0] lbufRd;
   logic signed [N-1:0] pmax;
   logic signed [N-1:0] winMax;
   logic                colLast;
   logic                rowLast;
   logic                oddCol;
   logic                lbufWe;

   // Pair max, window max and all next-state values; nothing moves unless valid is high.
   always_comb begin
      lbufIdx      = LW'(col_q >> 1);
      lbufRd       = lbuf_q[lbufIdx];
      colLast      = (col_q == CW'(IMG_W - 1));
      rowLast      = (row_q == RW'(IMG_H - 1));
      oddCol       = col_q[0];
      pmax         = (s.din > pair_q) ? s.din : pair_q;
      winMax       = (lbufRd > pmax) ? lbufRd : pmax;

      col_d        = col_q;
      row_d        = row_q;
      state_d      = state_q;
      pair_d       = pair_q;
      pool_out_d   = pool_out_q;
      pool_valid_d = 1'b0;
      frame_done_d = 1'b0;
      lbufWe       = 1'b0;

      if (s.valid) begin
         if (!oddCol) begin
            pair_d = s.din;
         end else if (state_q == ROW_EVEN) begin
            lbufWe = 1'b1;
         end else begin
            pool_out_d   = winMax;
            pool_valid_d = 1'b1;
            frame_done_d = colLast && rowLast;
         end

         if (colLast) begin
            col_d = '0;
            if (rowLast) begin
               row_d   = '0;
               state_d = ROW_EVEN;
            end else begin
               row_d   = row_q + RW'(1);
               state_d = (state_q == ROW_EVEN) ? ROW_ODD : ROW_EVEN;
            end
         end else begin
            col_d = col_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ROW_EVEN;
         col_q        <= '0;
         row_q        <= '0;
         pair_q       <= MIN_NEG;
         pool_out_q   <= MIN_NEG;
         pool_valid_q <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         col_q        <= col_d;
         row_q        <= row_d;
         pair_q       <= pair_d;
         pool_out_q   <= pool_out_d;
         pool_valid_q <= pool_valid_d;
         frame_done_q <= frame_done_d;
      end
   end

   // Line buffer needs no reset: every even row rewrites each entry before the odd row reads it.
   always_ff @(posedge clk) begin
      if (lbufWe) begin
         lbuf_q[lbufIdx] <= pmax;
      end
   end

   assign s.pool_out   = pool_out_q;
   assign s.pool_valid = pool_valid_q;
   assign s.frame_done = frame_done_q;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Directed bench for maxpool2x2_stream: a 4x4 instance for hand-computed frames and a
// 28x28 instance fed random data and checked against a window-max golden model.
module tb_maxpool2x2_stream;

   localparam logic signed [15:0] MIN_NEG = 16'sh8000;

   logic clk = 1'b0;
   logic reset;

   // Free-running clock, period 10.
   always #5 clk = ~clk;

   maxpool2x2_stream_if #(.N(16)) ifS ();
   maxpool2x2_stream_if #(.N(16)) ifB ();

   maxpool2x2_stream #(.N(16), .IMG_W(4), .IMG_H(4)) dutS (
      .clk   (clk),
      .reset (reset),
      .s     (ifS)
   );

   maxpool2x2_stream #(.N(16), .IMG_W(28), .IMG_H(28)) dutB (
      .clk   (clk),
      .reset (reset),
      .s     (ifB)
   );

   int                checks   = 0;
   int                failures = 0;
   int                outCount = 0;
   logic signed [15:0] lastS;
   logic signed [15:0] lastB;
   logic signed [15:0] d;
   logic signed [15:0] expB;
   logic               evB;
   logic signed [15:0] img [28][28];

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic signed [15:0] obs,
                              input logic signed [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Drive one cycle into the 4x4 instance and check all three outputs just after the edge.
   task automatic applyStimulus(input logic v, input logic signed [15:0] din,
                                input logic ev, input logic signed [15:0] eo,
                                input logic ed, input string tag);
      ifS.valid = v;
      ifS.din   = din;
      @(posedge clk);
      #1;
      if (ev) lastS = eo;
      checkOutput({tag, ".valid"}, 16'(ifS.pool_valid), 16'(ev));
      checkOutput({tag, ".out"},   ifS.pool_out,        lastS);
      checkOutput({tag, ".done"},  16'(ifS.frame_done), 16'(ed));
   endtask

   // Bottom-right pixel indices of the four windows of a 4x4 frame.
   function automatic logic isBr(input int p);
      return (p == 5) || (p == 7) || (p == 13) || (p == 15);
   endfunction

   function automatic logic signed [15:0] max2(input logic signed [15:0] a,
                                               input logic signed [15:0] b);
      return (a > b) ? a : b;
   endfunction

   initial begin
      reset     = 1'b1;
      ifS.valid = 1'b0;
      ifS.din   = '0;
      ifB.valid = 1'b0;
      ifB.din   = '0;
      lastS     = MIN_NEG;
      lastB     = MIN_NEG;

      #3;
      checkOutput("reset.valid", 16'(ifS.pool_valid), 16'd0);
      checkOutput("reset.out",   ifS.pool_out,        MIN_NEG);
      checkOutput("reset.done",  16'(ifS.frame_done), 16'd0);
      checkOutput("resetB.out",  ifB.pool_out,        MIN_NEG);
      @(posedge clk);
      #1;
      reset = 1'b0;

      $display("[TB] ramp frame");
      for (int p = 0; p < 16; p++)
         applyStimulus(1'b1, 16'(p), isBr(p), 16'(p), p == 15, "ramp");

      $display("[TB] signed window frame");
      for (int p = 0; p < 16; p++) begin
         d = (p == 0) ? -16'sd3 : (p == 1) ? -16'sd7 : (p == 4) ? -16'sd1 :
             (p == 5) ? -16'sd9 : MIN_NEG;
         applyStimulus(1'b1, d, isBr(p), (p == 5) ? -16'sd1 : MIN_NEG, p == 15, "signed");
      end

      $display("[TB] all-minimum frame");
      for (int p = 0; p < 16; p++)
         applyStimulus(1'b1, MIN_NEG, isBr(p), MIN_NEG, p == 15, "allmin");

      $display("[TB] ramp with gaps");
      for (int p = 0; p < 16; p++) begin
         applyStimulus(1'b1, 16'(p), isBr(p), 16'(p), p == 15, "gapramp");
         applyStimulus(1'b0, 16'sh7fff, 1'b0, 16'sd0, 1'b0, "gap");
      end

      $display("[TB] back-to-back frames");
      for (int p = 0; p < 16; p++)
         applyStimulus(1'b1, 16'(p), isBr(p), 16'(p), p == 15, "b2b0");
      for (int p = 0; p < 16; p++)
         applyStimulus(1'b1, 16'(p + 100), isBr(p), 16'(p + 100), p == 15, "b2b1");

      $display("[TB] reset mid-frame");
      for (int p = 0; p < 6; p++)
         applyStimulus(1'b1, 16'(p), isBr(p), 16'(p), 1'b0, "partial");
      ifS.valid = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      lastS = MIN_NEG;
      checkOutput("midreset.valid", 16'(ifS.pool_valid), 16'd0);
      checkOutput("midreset.out",   ifS.pool_out,        MIN_NEG);
      checkOutput("midreset.done",  16'(ifS.frame_done), 16'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      for (int p = 0; p < 16; p++)
         applyStimulus(1'b1, 16'(p), isBr(p), 16'(p), p == 15, "postreset");

      $display("[TB] max position and ties");
      for (int p = 0; p < 16; p++) begin
         d = ((p == 0) || (p == 3) || (p == 12) || (p == 15)) ? 16'sd50 : 16'sd0;
         applyStimulus(1'b1, d, isBr(p), 16'sd50, p == 15, "maxpos");
      end
      for (int p = 0; p < 16; p++) begin
         d = ((p == 1) || (p == 6) || (p == 10) || (p == 13)) ? 16'sd50 : 16'sd0;
         applyStimulus(1'b1, d, isBr(p), 16'sd50, p == 15, "maxpos2");
      end
      for (int p = 0; p < 16; p++)
         applyStimulus(1'b1, 16'sd50, isBr(p), 16'sd50, p == 15, "ties");
      applyStimulus(1'b0, 16'sd0, 1'b0, 16'sd0, 1'b0, "idle");

      $display("[TB] 28x28 random frame");
      for (int r = 0; r < 28; r++)
         for (int c = 0; c < 28; c++)
            img[r][c] = 16'($urandom);
      img[0][0] = MIN_NEG;
      img[1][1] = 16'sh7fff;
      img[2][2] = -16'sd1;
      img[3][3] = -16'sd1;
      img[2][3] = -16'sd1;
      img[3][2] = -16'sd1;
      for (int r = 0; r < 28; r++) begin
         for (int c = 0; c < 28; c++) begin
            if ($urandom_range(0, 4) == 0) begin
               ifB.valid = 1'b0;
               ifB.din   = 16'($urandom);
               @(posedge clk);
               #1;
               checkOutput("big.gapvalid", 16'(ifB.pool_valid), 16'd0);
            end
            ifB.valid = 1'b1;
            ifB.din   = img[r][c];
            @(posedge clk);
            #1;
            evB = (r % 2 == 1) && (c % 2 == 1);
            if (evB) begin
               expB  = max2(max2(img[r-1][c-1], img[r-1][c]), max2(img[r][c-1], img[r][c]));
               lastB = expB;
            end
            outCount += int'(ifB.pool_valid);
            checkOutput("big.valid", 16'(ifB.pool_valid), 16'(evB));
            checkOutput("big.out",   ifB.pool_out,        lastB);
            checkOutput("big.done",  16'(ifB.frame_done), 16'((r == 27) && (c == 27)));
         end
      end
      ifB.valid = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("big.count", 16'(outCount), 16'sd196);
      checkOutput("big.hold",  ifB.pool_out,  lastB);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
